// File: rtl/mesh_link_tx_arbiter.sv
// Round-robin arbiter for the send half of one mesh link: grants a requester, registers its word,
// and holds send_data/send_ready until the link reports send_done, then pulses that requester's ack.
module mesh_link_tx_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 32,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WORD_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ack,
  output logic [WORD_W-1:0]       send_data,
  output logic                    send_ready,
  input  logic                    send_done,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   send_data_q, send_data_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     last_q, last_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  int                  idx;

  // Search starts one past the previous winner and wraps, so the last winner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    send_data_d = send_data_q;
    grant_id_d  = grant_id_q;
    last_d      = last_q;
    req_ack     = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          send_data_d = req_data[int'(win_id)*WORD_W +: WORD_W];
          grant_id_d  = win_id;
          last_d      = win_id;
          state_d     = SEND;
        end
      end
      SEND: begin
        // Ack is combinational so the requester sees it in the same cycle the peer accepts.
        if (send_done) begin
          req_ack[grant_id_q] = 1'b1;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      send_data_q <= '0;
      grant_id_q  <= '0;
      last_q      <= ID_W'(N_REQ - 1);
    end else begin
      state_q     <= state_d;
      send_data_q <= send_data_d;
      grant_id_q  <= grant_id_d;
      last_q      <= last_d;
    end
  end

  assign send_ready = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign send_data  = send_data_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_mesh_link_tx_arbiter.sv
// Directed bench for mesh_link_tx_arbiter: reset, single grant, round-robin contention,
// backpressure, spurious done, dropped valid and reset during SEND.
module tb_mesh_link_tx_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           CLK;
  logic           nRST;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [W-1:0]   send_data;
  logic           send_ready;
  logic           send_done;
  logic           busy;
  logic [1:0]     grant_id;

  logic           done_auto;
  logic           done_manual;

  int checks   = 0;
  int failures = 0;

  assign send_done = done_auto ? send_ready : done_manual;

  mesh_link_tx_arbiter #(.N_REQ(N), .WORD_W(W)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .send_data  (send_data),
    .send_ready (send_ready),
    .send_done  (send_done),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST        = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    done_auto   = 1'b0;
    done_manual = 1'b0;
    #2;
    checks++; if (send_ready !== 1'b0) begin failures++; $display("FAIL reset_send_ready got=%b exp=0", send_ready); end
    checks++; if (send_data !== 32'h0) begin failures++; $display("FAIL reset_send_data got=%h exp=00000000", send_data); end
    checks++; if (req_ack !== 4'b0000) begin failures++; $display("FAIL reset_req_ack got=%b exp=0000", req_ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    tick();
    tick();
    nRST = 1'b1;
    $display("reset released");
  endtask

  task automatic test_single();
    done_auto = 1'b1;
    req_data[1*W +: W] = 32'hDEADBEEF;
    req_valid = 4'b0010;
    tick();
    checks++; if (send_ready !== 1'b1) begin failures++; $display("FAIL single_send_ready got=%b exp=1", send_ready); end
    checks++; if (send_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_send_data got=%h exp=deadbeef", send_data); end
    checks++; if (req_ack !== 4'b0010) begin failures++; $display("FAIL single_req_ack got=%b exp=0010", req_ack); end
    checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL single_grant_id got=%0d exp=1", grant_id); end
    req_valid = 4'b0000;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy); end
    checks++; if (req_ack !== 4'b0000) begin failures++; $display("FAIL single_ack_after got=%b exp=0000", req_ack); end
    $display("single grant id=1 data=%h", send_data);
    done_auto = 1'b0;
  endtask

  task automatic test_contention();
    int exp_id;
    logic [W-1:0] exp_word;
    pulse_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hA5000000 | 32'(i * 16 + 1);
    done_auto = 1'b1;
    req_valid = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      exp_id   = g % N;
      exp_word = 32'hA5000000 | 32'(exp_id * 16 + 1);
      tick();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rr_busy[%0d] got=%b exp=1", g, busy); end
      checks++; if (grant_id !== 2'(exp_id)) begin failures++; $display("FAIL rr_grant_id[%0d] got=%0d exp=%0d", g, grant_id, exp_id); end
      checks++; if (send_data !== exp_word) begin failures++; $display("FAIL rr_send_data[%0d] got=%h exp=%h", g, send_data, exp_word); end
      checks++; if (req_ack !== 4'(1 << exp_id)) begin failures++; $display("FAIL rr_req_ack[%0d] got=%b exp=%b", g, req_ack, 4'(1 << exp_id)); end
      $display("contention grant %0d id=%0d data=%h", g, grant_id, send_data);
      if (g == 5) req_valid = 4'b0000;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle_busy[%0d] got=%b exp=0", g, busy); end
    end
    done_auto = 1'b0;
  endtask

  task automatic test_backpressure();
    pulse_reset();
    done_manual = 1'b0;
    req_data[2*W +: W] = 32'h12345678;
    req_valid = 4'b0100;
    tick();
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL bp_grant got=%0d exp=2", grant_id); end
    for (int c = 0; c < 5; c++) begin
      req_data[2*W +: W] = req_data[2*W +: W] ^ 32'hFFFFFFFF;
      req_valid[0] = ~req_valid[0];
      tick();
      checks++; if (send_data !== 32'h12345678) begin failures++; $display("FAIL bp_send_data[%0d] got=%h exp=12345678", c, send_data); end
      checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL bp_grant_id[%0d] got=%0d exp=2", c, grant_id); end
      checks++; if (req_ack !== 4'b0000) begin failures++; $display("FAIL bp_req_ack[%0d] got=%b exp=0000", c, req_ack); end
      checks++; if (send_ready !== 1'b1) begin failures++; $display("FAIL bp_send_ready[%0d] got=%b exp=1", c, send_ready); end
    end
    done_manual = 1'b1;
    #1;
    checks++; if (req_ack !== 4'b0100) begin failures++; $display("FAIL bp_final_ack got=%b exp=0100", req_ack); end
    $display("backpressure done id=2 ack=%b", req_ack);
    req_valid = 4'b0000;
    tick();
    done_manual = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_spurious_and_drop();
    req_valid   = 4'b0000;
    done_manual = 1'b1;
    #1;
    checks++; if (req_ack !== 4'b0000) begin failures++; $display("FAIL spur_ack got=%b exp=0000", req_ack); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spur_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL spur_grant_id got=%0d exp=2", grant_id); end
    done_manual = 1'b0;
    $display("spurious done ignored");
    req_data[1*W +: W] = 32'hCAFEF00D;
    req_valid = 4'b0010;
    tick();
    checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL drop_grant got=%0d exp=1", grant_id); end
    req_valid = 4'b0000;
    req_data[1*W +: W] = 32'h0;
    tick();
    checks++; if (send_data !== 32'hCAFEF00D) begin failures++; $display("FAIL drop_send_data got=%h exp=cafef00d", send_data); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy got=%b exp=1", busy); end
    done_manual = 1'b1;
    #1;
    checks++; if (req_ack !== 4'b0010) begin failures++; $display("FAIL drop_ack got=%b exp=0010", req_ack); end
    tick();
    done_manual = 1'b0;
    $display("dropped valid word completed");
  endtask

  task automatic test_reset_mid_send();
    req_data[3*W +: W] = 32'h33333333;
    req_data[0*W +: W] = 32'h00000AAA;
    req_valid = 4'b1000;
    tick();
    checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL mid_grant got=%0d exp=3", grant_id); end
    done_manual = 1'b1;
    nRST = 1'b0;
    #1;
    checks++; if (send_ready !== 1'b0) begin failures++; $display("FAIL mid_send_ready got=%b exp=0", send_ready); end
    checks++; if (send_data !== 32'h0) begin failures++; $display("FAIL mid_send_data got=%h exp=00000000", send_data); end
    checks++; if (req_ack !== 4'b0000) begin failures++; $display("FAIL mid_req_ack got=%b exp=0000", req_ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL mid_grant_id got=%0d exp=0", grant_id); end
    done_manual = 1'b0;
    req_valid   = 4'b1001;
    #1;
    nRST = 1'b1;
    tick();
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL mid_restart_grant got=%0d exp=0", grant_id); end
    checks++; if (send_data !== 32'h00000AAA) begin failures++; $display("FAIL mid_restart_data got=%h exp=00000aaa", send_data); end
    $display("reset mid-send restart id=%0d", grant_id);
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_spurious_and_drop();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
